// File: rtl/theta_stage_if.sv
// Slice-stream bundle for theta_stage: capture port, emit port and status.
// The master side is the producer/consumer environment; the slave side is the stage.
interface theta_stage_if #(
  parameter int IDX_W = 6
);
  logic             start;
  logic             in_valid;
  logic [IDX_W-1:0] in_index;
  logic [24:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [24:0]      out_data;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, in_index, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_data, busy, done
  );

  modport slave (
    input  start, in_valid, in_index, in_data, out_ready,
    output in_ready, out_valid, out_index, out_data, busy, done
  );
endinterface

// File: rtl/theta_stage.sv
// Keccak theta stage: captures 64 slices in any order, keeps per-slice column
// parities, then streams the theta-mixed slices out in index order.
module theta_stage #(
  parameter int N_SLICE = 64,
  parameter int IDX_W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  theta_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, DONE} state_t;

  state_t             state_q;
  logic [24:0]        mem_q [N_SLICE];
  logic [4:0]         par_q [N_SLICE];
  logic [N_SLICE-1:0] flag_q;
  logic [IDX_W:0]     fill_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic [IDX_W-1:0]   zprev;
  logic [24:0]        theta_d;

  function automatic logic [4:0] col_par(input logic [24:0] s);
    logic [4:0] p;
    p = '0;
    for (int unsigned x = 0; x < 5; x++)
      for (int unsigned y = 0; y < 5; y++)
        p[x] = p[x] ^ s[5*y+x];
    return p;
  endfunction

  assign accept = bus.in_valid && in_ready_q;
  // Index wraps naturally in IDX_W bits, so slice 0 pairs with slice N_SLICE-1.
  assign zprev  = cnt_q - 1'b1;

  always_comb begin
    theta_d = '0;
    for (int unsigned y = 0; y < 5; y++)
      for (int unsigned x = 0; x < 5; x++)
        theta_d[5*y+x] = mem_q[cnt_q][5*y+x]
                       ^ par_q[cnt_q][(x+4)%5]
                       ^ par_q[zprev][(x+1)%5];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < N_SLICE; i++) begin
        mem_q[i] <= '0;
        par_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            flag_q     <= '0;
            fill_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (accept) begin
            mem_q[bus.in_index]  <= bus.in_data;
            par_q[bus.in_index]  <= col_par(bus.in_data);
            flag_q[bus.in_index] <= 1'b1;
            // Only a first write to an index advances the fill count.
            if (!flag_q[bus.in_index]) begin
              fill_q <= fill_q + 1'b1;
              if (fill_q == (IDX_W+1)'(N_SLICE-1)) begin
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                state_q     <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (cnt_q == IDX_W'(N_SLICE-1)) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              cnt_q       <= '0;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = cnt_q;
  assign bus.out_data  = out_valid_q ? theta_d : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
